if_stage: RTL and testbench

- Instruction-fetch stage of the MIPS pipeline.
- Holds the PC and issues requests to instruction memory over a variable-latency req/ready handshake.
- Loads the IF/ID pipeline register, whose instr_d[31:26] drives the main decoder's op input.
- Takes stall from the hazard unit, branch/jump redirects from decode, and flushes wrong-path fetches; no branch delay slot.

---
 rtl/if_stage_if.sv | 28 ++
 rtl/if_stage.sv | 160 ++++++++++++++++
 tb/tb_if_stage.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and the
// instruction memory (slave).
//
// Handshake: imem_req is the request valid and imem_addr the byte address.
// A transfer completes on a rising edge where imem_req & imem_ready are both 1,
// and imem_rdata carries the word in that same cycle. While imem_req=1 and
// imem_ready=0 the master holds imem_addr stable. imem_ready is meaningful only
// while imem_req=1.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage of the MIPS pipeline: owns the fetch PC, talks to
// instruction memory over a variable-latency req/ready bus and loads the IF/ID
// register. Handles stall from the hazard unit, jump/branch redirects from
// decode (no delay slot) and drops wrong-path responses.
// dbg_state encoding: 0 = FETCH, 1 = HOLD, 2 = DISCARD.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PCW      = 32
) (
    input  logic           clk,
    input  logic           rst,
    if_stage_if.master     imem,
    input  logic           stall_d,
    input  logic           jump_d,
    input  logic           branch_taken_d,
    input  logic [PCW-1:0] branch_target_d,
    output logic [31:0]    instr_d,
    output logic [PCW-1:0] pc_plus4_d,
    output logic           valid_d,
    output logic [PCW-1:0] pc_f,
    output logic [1:0]     dbg_state
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t         r_state;
    logic [PCW-1:0] r_pc;
    logic [31:0]    r_instr_d;
    logic [PCW-1:0] r_pc4_d;
    logic           r_valid_d;
    logic [31:0]    r_hold_instr;
    logic [PCW-1:0] r_hold_pc4;
    logic [PCW-1:0] r_redir_pc;

    state_t         w_state_nx;
    logic [PCW-1:0] w_pc_nx;
    logic [31:0]    w_instr_nx;
    logic [PCW-1:0] w_pc4_nx;
    logic           w_valid_nx;
    logic [31:0]    w_hold_instr_nx;
    logic [PCW-1:0] w_hold_pc4_nx;
    logic [PCW-1:0] w_redir_nx;

    logic           w_req;
    logic           w_accept;
    logic           w_redirect;
    logic [PCW-1:0] w_target;
    logic [PCW-1:0] w_pc_plus4;

    // Request is suppressed during reset and while a word is parked in HOLD.
    assign w_req      = ~rst & (r_state != ST_HOLD);
    assign w_accept   = w_req & imem.imem_ready;
    // A redirect only counts for a real, non-stalled instruction in ID.
    assign w_redirect = r_valid_d & ~stall_d & (jump_d | branch_taken_d);
    // Jump wins over branch; jump target keeps the upper nibble of PC+4.
    assign w_target   = jump_d ? {r_pc4_d[PCW-1:PCW-4], r_instr_d[25:0], 2'b00}
                               : branch_target_d;
    // Wraps modulo 2^PCW.
    assign w_pc_plus4 = r_pc + {{(PCW-3){1'b0}}, 3'b100};

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign instr_d        = r_instr_d;
    assign pc_plus4_d     = r_pc4_d;
    assign valid_d        = r_valid_d;
    assign pc_f           = r_pc;
    assign dbg_state      = r_state;

    // Next-state and next-register values for the fetch FSM.
    always_comb begin
        w_state_nx      = r_state;
        w_pc_nx         = r_pc;
        w_instr_nx      = r_instr_d;
        w_pc4_nx        = r_pc4_d;
        w_valid_nx      = r_valid_d;
        w_hold_instr_nx = r_hold_instr;
        w_hold_pc4_nx   = r_hold_pc4;
        w_redir_nx      = r_redir_pc;
        case (r_state)
            ST_FETCH: begin
                if (w_accept) begin
                    if (w_redirect) begin
                        // Returned word is on the wrong path.
                        w_pc_nx    = w_target;
                        w_valid_nx = 1'b0;
                    end else if (stall_d) begin
                        // ID is frozen: park the word until the stall clears.
                        w_hold_instr_nx = imem.imem_rdata;
                        w_hold_pc4_nx   = w_pc_plus4;
                        w_state_nx      = ST_HOLD;
                    end else begin
                        w_instr_nx = imem.imem_rdata;
                        w_pc4_nx   = w_pc_plus4;
                        w_valid_nx = 1'b1;
                        w_pc_nx    = w_pc_plus4;
                    end
                end else if (w_redirect) begin
                    // Request in flight: keep the address, drop its response later.
                    w_redir_nx = w_target;
                    w_valid_nx = 1'b0;
                    w_state_nx = ST_DISCARD;
                end else if (!stall_d) begin
                    w_valid_nx = 1'b0;
                end
            end
            ST_HOLD: begin
                if (!stall_d) begin
                    if (w_redirect) begin
                        w_pc_nx    = w_target;
                        w_valid_nx = 1'b0;
                    end else begin
                        w_instr_nx = r_hold_instr;
                        w_pc4_nx   = r_hold_pc4;
                        w_valid_nx = 1'b1;
                        w_pc_nx    = w_pc_plus4;
                    end
                    w_state_nx = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                // ID holds a bubble here, so stall and redirect have no effect.
                if (w_accept) begin
                    w_pc_nx    = r_redir_pc;
                    w_state_nx = ST_FETCH;
                end
            end
            default: begin
                w_state_nx = ST_FETCH;
            end
        endcase
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC[PCW-1:0];
            r_instr_d    <= '0;
            r_pc4_d      <= '0;
            r_valid_d    <= 1'b0;
            r_hold_instr <= '0;
            r_hold_pc4   <= '0;
            r_redir_pc   <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_pc         <= w_pc_nx;
            r_instr_d    <= w_instr_nx;
            r_pc4_d      <= w_pc4_nx;
            r_valid_d    <= w_valid_nx;
            r_hold_instr <= w_hold_instr_nx;
            r_hold_pc4   <= w_hold_pc4_nx;
            r_redir_pc   <= w_redir_nx;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed walk through fetch, wait, stall, jump, branch,
// reset and PC-wrap cases, then randomized traffic checked against an
// architectural model of the expected instruction stream.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ST_FETCH = 32'd0;
  localparam logic [31:0] ST_HOLD = 32'd1;
  localparam logic [31:0] ST_DISCARD = 32'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall_d;
  logic        jump_d;
  logic        branch_taken_d;
  logic [31:0] branch_target_d;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic [31:0] pc_f;
  logic [1:0]  dbg_state;
  logic        rand_mode = 1'b0;

  int checks = 0;
  int errors = 0;

  if_stage_if bus ();

  if_stage #(.RESET_PC(RESET_PC), .PCW(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem            (bus),
    .stall_d         (stall_d),
    .jump_d          (jump_d),
    .branch_taken_d  (branch_taken_d),
    .branch_target_d (branch_target_d),
    .instr_d         (instr_d),
    .pc_plus4_d      (pc_plus4_d),
    .valid_d         (valid_d),
    .pc_f            (pc_f),
    .dbg_state       (dbg_state)
  );

  // ---------------- instruction memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic rm);
    if (rm) return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    else if (a == 32'h0000_0010) return 32'h0800_0040;
    else return a | 32'h0000_1000;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr, rand_mode);

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard: architectural instruction stream ----------------
  // Every instruction leaving ID (valid_d & ~stall_d) must be the word at the
  // next architectural PC; a jump/branch seen there sets the following PC.
  logic [31:0] m_pc;
  logic [31:0] m_addr_prev;
  logic        m_pending;
  logic [31:0] m_word;
  logic [31:0] exp_q[$];
  int          idle;

  initial begin
    m_pc = RESET_PC;
    m_pending = 1'b0;
    m_addr_prev = '0;
    idle = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_pc = RESET_PC;
        m_pending = 1'b0;
        idle = 0;
        exp_q.delete();
      end else begin
        if (m_pending) chk("addr_stable", bus.imem_addr, m_addr_prev);
        m_pending = bus.imem_req & ~bus.imem_ready;
        m_addr_prev = bus.imem_addr;
        if (valid_d && !stall_d) begin
          m_word = mem_word(m_pc, rand_mode);
          exp_q.push_back(m_word);
          exp_q.push_back(m_pc + 32'd4);
          chk("sb_instr", instr_d, exp_q.pop_front());
          chk("sb_pc4", pc_plus4_d, exp_q.pop_front());
          if (jump_d) m_pc = {m_pc_plus4_hi(m_pc), m_word[25:0], 2'b00};
          else if (branch_taken_d) m_pc = branch_target_d;
          else m_pc = m_pc + 32'd4;
          idle = 0;
        end else begin
          idle++;
          if (idle >= 100) begin
            chk("progress_timeout", 32'(idle), 32'd0);
            idle = 0;
          end
        end
      end
    end
  end

  function automatic logic [3:0] m_pc_plus4_hi(input logic [31:0] pc);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    return p4[31:28];
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst = 1'b1;
    stall_d = 1'b0;
    jump_d = 1'b0;
    branch_taken_d = 1'b0;
    branch_target_d = '0;
    bus.imem_ready = 1'b1;

    repeat (3) tick();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_pc", pc_f, RESET_PC);
    chk("rst_valid", 32'(valid_d), 32'd0);
    chk("rst_instr", instr_d, 32'd0);
    chk("rst_pc4", pc_plus4_d, 32'd0);
    chk("rst_state", 32'(dbg_state), ST_FETCH);
    rst = 1'b0;
    #1;
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr, RESET_PC);

    // back-to-back fetch
    tick();
    chk("seq_addr1", bus.imem_addr, 32'h4);
    chk("seq_valid1", 32'(valid_d), 32'd1);
    chk("seq_instr1", instr_d, 32'h1000);
    chk("seq_pc4_1", pc_plus4_d, 32'h4);
    tick();
    chk("seq_addr2", bus.imem_addr, 32'h8);
    chk("seq_instr2", instr_d, 32'h1004);
    chk("seq_pc4_2", pc_plus4_d, 32'h8);
    bus.imem_ready = 1'b0;

    // memory wait on 0x8
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_addr", bus.imem_addr, 32'h8);
      chk("wait_valid", 32'(valid_d), 32'd0);
    end
    bus.imem_ready = 1'b1;
    tick();
    chk("wait_instr", instr_d, 32'h1008);
    chk("wait_pc4", pc_plus4_d, 32'hC);
    chk("wait_valid_after", 32'(valid_d), 32'd1);
    chk("wait_addr_after", bus.imem_addr, 32'hC);
    stall_d = 1'b1;

    // stall coinciding with accept of 0xC
    tick();
    chk("hold_state", 32'(dbg_state), ST_HOLD);
    chk("hold_req", 32'(bus.imem_req), 32'd0);
    chk("hold_instr", instr_d, 32'h1008);
    chk("hold_pc4", pc_plus4_d, 32'hC);
    chk("hold_pc", pc_f, 32'hC);
    tick();
    chk("hold_state2", 32'(dbg_state), ST_HOLD);
    chk("hold_instr2", instr_d, 32'h1008);
    stall_d = 1'b0;
    tick();
    chk("release_instr", instr_d, 32'h100C);
    chk("release_pc4", pc_plus4_d, 32'h10);
    chk("release_addr", bus.imem_addr, 32'h10);
    chk("release_state", 32'(dbg_state), ST_FETCH);

    // jump in ID with same-cycle accept
    tick();
    chk("j_instr", instr_d, 32'h0800_0040);
    chk("j_pc4", pc_plus4_d, 32'h14);
    jump_d = 1'b1;
    tick();
    chk("j_addr", bus.imem_addr, 32'h100);
    chk("j_bubble", 32'(valid_d), 32'd0);
    jump_d = 1'b0;
    tick();
    chk("j_tgt_instr", instr_d, 32'h1100);
    chk("j_tgt_pc4", pc_plus4_d, 32'h104);

    // branch while response pending -> DISCARD
    branch_taken_d = 1'b1;
    branch_target_d = 32'h200;
    bus.imem_ready = 1'b0;
    tick();
    chk("disc_state", 32'(dbg_state), ST_DISCARD);
    chk("disc_addr", bus.imem_addr, 32'h104);
    chk("disc_req", 32'(bus.imem_req), 32'd1);
    chk("disc_valid", 32'(valid_d), 32'd0);
    branch_taken_d = 1'b0;
    tick();
    chk("disc_addr2", bus.imem_addr, 32'h104);
    chk("disc_valid2", 32'(valid_d), 32'd0);
    bus.imem_ready = 1'b1;
    tick();
    chk("disc_redir_addr", bus.imem_addr, 32'h200);
    chk("disc_no_wrong_path", 32'(valid_d), 32'd0);
    chk("disc_exit_state", 32'(dbg_state), ST_FETCH);
    tick();
    chk("br_tgt_instr", instr_d, 32'h1200);
    chk("br_tgt_pc4", pc_plus4_d, 32'h204);

    // reset in the middle of HOLD
    stall_d = 1'b1;
    tick();
    chk("rh_state", 32'(dbg_state), ST_HOLD);
    rst = 1'b1;
    stall_d = 1'b0;
    tick();
    chk("rh_pc", pc_f, RESET_PC);
    chk("rh_valid", 32'(valid_d), 32'd0);
    chk("rh_state_after", 32'(dbg_state), ST_FETCH);
    rst = 1'b0;
    #1;
    chk("rh_req", 32'(bus.imem_req), 32'd1);
    chk("rh_addr", bus.imem_addr, RESET_PC);

    // reset in the middle of DISCARD
    tick();
    chk("rd_instr", instr_d, 32'h1000);
    branch_taken_d = 1'b1;
    branch_target_d = 32'h300;
    bus.imem_ready = 1'b0;
    tick();
    chk("rd_state", 32'(dbg_state), ST_DISCARD);
    rst = 1'b1;
    branch_taken_d = 1'b0;
    tick();
    chk("rd_pc", pc_f, RESET_PC);
    chk("rd_valid", 32'(valid_d), 32'd0);
    chk("rd_state_after", 32'(dbg_state), ST_FETCH);
    rst = 1'b0;
    bus.imem_ready = 1'b1;
    #1;
    chk("rd_req", 32'(bus.imem_req), 32'd1);
    chk("rd_addr", bus.imem_addr, RESET_PC);
    tick();
    chk("rd_instr_after", instr_d, 32'h1000);
    chk("rd_addr_after", bus.imem_addr, 32'h4);

    // PC wrap at 0xFFFF_FFFC
    branch_taken_d = 1'b1;
    branch_target_d = 32'hFFFF_FFFC;
    tick();
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_bubble", 32'(valid_d), 32'd0);
    branch_taken_d = 1'b0;
    tick();
    chk("wrap_instr", instr_d, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_d, 32'h0);
    chk("wrap_next_addr", bus.imem_addr, 32'h0);

    // jump beats branch when both are asserted
    jump_d = 1'b1;
    branch_taken_d = 1'b1;
    branch_target_d = 32'h400;
    tick();
    chk("prio_addr", bus.imem_addr, 32'h0FFF_FFF0);
    chk("prio_bubble", 32'(valid_d), 32'd0);
    jump_d = 1'b0;
    branch_taken_d = 1'b0;

    // randomized traffic against the stream model
    rst = 1'b1;
    tick();
    rand_mode = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3000) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      bus.imem_ready = ($urandom_range(0, 3) != 0);
      stall_d = ($urandom_range(0, 4) == 0);
      jump_d = ($urandom_range(0, 9) == 0);
      branch_taken_d = ($urandom_range(0, 7) == 0);
      branch_target_d = {$urandom(), 2'b00} >> 0;
      branch_target_d[1:0] = 2'b00;
    end
    rst = 1'b0;
    stall_d = 1'b0;
    jump_d = 1'b0;
    branch_taken_d = 1'b0;
    bus.imem_ready = 1'b1;
    repeat (5) tick();

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
